// File: rtl/mux_share_arbiter_pkg.sv
// mux_share_arbiter_pkg: state encodings and default parameters shared by the arbiter files
package mux_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 4;
endpackage

// File: rtl/mux_share_arbiter_mux2_data.sv
// mux2_data: DATA_W-wide 2:1 data mux steered by the arbiter select
module mux2_data #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a shared 2:1 mux with bounded bursts and a registered output
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              owner_valid
);
  state_e            state_q, state_d;
  logic              last_q, last_d, sel_q, sel_d, out_valid_q, out_valid_d;
  logic [3:0]        hold_q, hold_d, hold_inc;
  logic [DATA_W-1:0] out_data_q, out_data_d, mux_data;
  logic              owning, own_v, oth_v, rdy, xfer, hit, rel;

  mux2_data #(.DATA_W(DATA_W)) u_mux (
    .sel(sel_q),
    .in0(req0_data),
    .in1(req1_data),
    .out(mux_data)
  );

  // while owning, sel_q always names the owner, so it doubles as the owner index
  always_comb begin
    owning      = state_q != IDLE;
    own_v       = sel_q ? req1_valid : req0_valid;
    oth_v       = sel_q ? req0_valid : req1_valid;
    rdy         = owning && (!out_valid_q || out_ready);
    xfer        = rdy && own_v;
    hold_inc    = hold_q + 4'd1;
    hit         = xfer && (hold_inc == 4'(MAX_HOLD));
    rel         = owning && (!own_v || (hit && oth_v));
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    if (!owning) begin
      if (req0_valid || req1_valid) begin
        sel_d   = (req0_valid && req1_valid) ? !last_q : req1_valid;
        state_d = sel_d ? OWN1 : OWN0;
      end
    end else if (rel) begin
      last_d  = sel_q;
      hold_d  = 4'd0;
      sel_d   = oth_v ? !sel_q : sel_q;
      state_d = !oth_v ? IDLE : (sel_q ? OWN0 : OWN1);
    end else begin
      hold_d  = hit ? 4'd0 : (xfer ? hold_inc : hold_q);
    end
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = xfer ? mux_data : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      hold_q      <= 4'd0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign req0_ready  = rdy && !sel_q;
  assign req1_ready  = rdy && sel_q;
  assign owner_valid = owning;
  assign sel         = sel_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed checks of arbitration, bursts, backpressure and reset
module tb_mux_share_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, ordy = 1'b1;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       r0, r1, ov, sel, own;
  logic [7:0] od;
  int         n_tests = 0, n_fail = 0;
  int         na, nb;

  mux_share_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .out_valid(ov), .out_data(od), .out_ready(ordy),
    .sel(sel), .owner_valid(own)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    tick; tick;
    chk("rst_ov", ov, 0); chk("rst_od", od, 0); chk("rst_sel", sel, 0);
    chk("rst_own", own, 0); chk("rst_r0", r0, 0); chk("rst_r1", r1, 0);
    rst = 1'b0;
    #1;
    chk("idle_r0", r0, 0); chk("idle_r1", r1, 0);
    tick;
    chk("grant0_own", own, 1); chk("grant0_sel", sel, 0);
    v0 = 1'b0; v1 = 1'b0;
    #1;
    chk("grant0_r1", r1, 0);
    tick;
    chk("drop_own", own, 0); chk("drop_ov", ov, 0);

    v0 = 1'b1; d0 = 8'h11;
    tick;
    chk("ss_grant_own", own, 1); chk("ss_grant_sel", sel, 0); chk("ss_grant_ov", ov, 0);
    tick;
    chk("ss_b0", od, 8'h11); chk("ss_v0", ov, 1); chk("ss_sel0", sel, 0);
    d0 = 8'h22;
    tick;
    chk("ss_b1", od, 8'h22); chk("ss_sel1", sel, 0);
    d0 = 8'h33;
    tick;
    chk("ss_b2", od, 8'h33); chk("ss_sel2", sel, 0);
    v0 = 1'b0;
    tick;
    chk("ss_end_own", own, 0); chk("ss_end_ov", ov, 0);

    v1 = 1'b1; d1 = 8'hC0;
    tick;
    chk("solo_grant_sel", sel, 1); chk("solo_grant_own", own, 1); chk("solo_grant_ov", ov, 0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("solo_data", od, 32'hC0 + i); chk("solo_ov", ov, 1);
      chk("solo_sel", sel, 1); chk("solo_own", own, 1);
      d1 = 8'(8'hC1 + i);
      if (i == 9) v1 = 1'b0;
    end
    tick;
    chk("solo_end_own", own, 0); chk("solo_end_ov", ov, 0);

    na = 0; nb = 0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'hA0; d1 = 8'hB0;
    tick;
    chk("cont_grant_sel", sel, 0);
    for (int n = 0; n < 16; n++) begin
      tick;
      if (((n / 4) % 2) == 0) begin
        chk("cont_a", od, 32'hA0 + na);
        na++;
      end else begin
        chk("cont_b", od, 32'hB0 + nb);
        nb++;
      end
      chk("cont_ov", ov, 1);
      chk("cont_sel", sel, ((n + 1) / 4) % 2);
      d0 = 8'(8'hA0 + na); d1 = 8'(8'hB0 + nb);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick;
    chk("cont_end_own", own, 0);

    v0 = 1'b1; d0 = 8'h50;
    tick;
    chk("bp_grant_sel", sel, 0);
    tick;
    chk("bp_b0", od, 8'h50);
    d0 = 8'h51;
    tick;
    chk("bp_b1", od, 8'h51);
    d0 = 8'h52; ordy = 1'b0;
    #1;
    chk("bp_r0_low", r0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_od", od, 8'h51); chk("bp_hold_ov", ov, 1);
      #1;
      chk("bp_hold_r0", r0, 0);
    end
    ordy = 1'b1;
    #1;
    chk("bp_r0_high", r0, 1);
    tick;
    chk("bp_b2", od, 8'h52);
    d0 = 8'h53;
    tick;
    chk("bp_b3", od, 8'h53); chk("bp_wrap_own", own, 1); chk("bp_wrap_sel", sel, 0);
    d0 = 8'h54;
    tick;
    chk("bp_b4", od, 8'h54); chk("bp_b4_ov", ov, 1);
    v0 = 1'b0;
    tick;
    chk("bp_end_own", own, 0); chk("bp_end_ov", ov, 0);

    v0 = 1'b1; d0 = 8'h60;
    tick;
    tick;
    chk("mr_b0", od, 8'h60);
    d0 = 8'h61;
    tick;
    chk("mr_b1", od, 8'h61);
    d0 = 8'h62; rst = 1'b1; v1 = 1'b1;
    tick;
    chk("mr_ov", ov, 0); chk("mr_od", od, 0); chk("mr_own", own, 0); chk("mr_sel", sel, 0);
    chk("mr_r0", r0, 0); chk("mr_r1", r1, 0);
    rst = 1'b0;
    tick;
    chk("mr_regrant_own", own, 1); chk("mr_regrant_sel", sel, 0);
    #1;
    chk("mr_regrant_r0", r0, 1); chk("mr_regrant_r1", r1, 0);
    tick;
    chk("mr_b2", od, 8'h62); chk("mr_b2_ov", ov, 1);
    v0 = 1'b0; v1 = 1'b0;
    tick;
    chk("mr_end_own", own, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
